// File: rtl/cv32e40p_instr_port_arbiter.sv
// Two-requester round-robin arbiter for the OBI instruction port, with in-order response routing.
// Optional performance counters are enabled by defining CV32E40P_ARB_PERF_CNT_EN.
module cv32e40p_instr_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [1:0][31:0] addr_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       rvalid_o,
  output logic [31:0]      rdata_o,
  output logic             err_o,
  output logic             instr_req_o,
  output logic [31:0]      instr_addr_o,
  input  logic             instr_gnt_i,
  input  logic             instr_rvalid_i,
  input  logic [31:0]      instr_rdata_i,
  input  logic             instr_err_i,
  output logic             busy_o,
`ifdef CV32E40P_ARB_PERF_CNT_EN
  output logic [31:0]      contention_cnt_o,
  output logic [31:0]      lock_stall_cnt_o,
`endif
  output logic             proto_err_o
);

  localparam int unsigned      PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic [CNT_W-1:0]           r_count;
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic                       r_rr_prio;
  logic                       r_lock;
  logic                       r_lock_id;
  logic                       r_proto_err;

  logic w_sel;
  logic w_grant;
  logic w_resp;
  logic w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_sel = 1'b0;
    if (r_lock)                w_sel = r_lock_id;
    else if (req_i == 2'b10)   w_sel = 1'b1;
    else if (req_i == 2'b11)   w_sel = r_rr_prio;
  end

  // The lock overrides the outstanding limit so a pending address phase is never withdrawn.
  assign instr_req_o  = req_i[w_sel] & ((r_count < MAX_CNT) | r_lock);
  assign instr_addr_o = addr_i[w_sel];
  assign w_grant      = instr_req_o & instr_gnt_i;
  assign w_resp       = instr_rvalid_i & (r_count != '0);
  assign w_head       = r_fifo[r_rd_ptr];

  always_comb begin
    gnt_o           = 2'b00;
    gnt_o[w_sel]    = w_grant;
    rvalid_o        = 2'b00;
    rvalid_o[w_head] = w_resp;
  end

  assign rdata_o     = instr_rdata_i;
  assign err_o       = instr_err_i;
  assign busy_o      = (r_count != '0) | instr_req_o;
  assign proto_err_o = r_proto_err;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rr_prio   <= 1'b0;
      r_lock      <= 1'b0;
      r_lock_id   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      case ({w_grant, w_resp})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_grant) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_resp)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_grant) begin
        r_lock <= 1'b0;
      end else if (instr_req_o) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_sel;
      end
      if (w_grant && (req_i == 2'b11)) r_rr_prio <= ~w_sel;
      if (instr_rvalid_i && (r_count == '0)) r_proto_err <= 1'b1;
    end
  end

  // NOTE: ID storage needs no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_grant) r_fifo[r_wr_ptr] <= w_sel;
  end

`ifdef CV32E40P_ARB_PERF_CNT_EN
  logic [31:0] r_contention_cnt;
  logic [31:0] r_lock_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_contention_cnt <= '0;
      r_lock_stall_cnt <= '0;
    end else begin
      if ((req_i == 2'b11) && (r_contention_cnt != '1))
        r_contention_cnt <= r_contention_cnt + 32'd1;
      if (r_lock && req_i[~r_lock_id] && (r_lock_stall_cnt != '1))
        r_lock_stall_cnt <= r_lock_stall_cnt + 32'd1;
    end
  end

  assign contention_cnt_o = r_contention_cnt;
  assign lock_stall_cnt_o = r_lock_stall_cnt;
`endif

endmodule

// File: tb/tb_cv32e40p_instr_port_arbiter.sv
// Directed bench for cv32e40p_instr_port_arbiter: queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_cv32e40p_instr_port_arbiter;

  localparam int MAX = 2;

  logic             clk;
  logic             rst;
  logic [1:0]       req_i;
  logic [1:0][31:0] addr_i;
  logic [1:0]       gnt_o;
  logic [1:0]       rvalid_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic             instr_req_o;
  logic [31:0]      instr_addr_o;
  logic             instr_gnt_i;
  logic             instr_rvalid_i;
  logic [31:0]      instr_rdata_i;
  logic             instr_err_i;
  logic             busy_o;
  logic             proto_err_o;
`ifdef CV32E40P_ARB_PERF_CNT_EN
  logic [31:0]      contention_cnt_o;
  logic [31:0]      lock_stall_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cv32e40p_instr_port_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .addr_i         (addr_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o),
`ifdef CV32E40P_ARB_PERF_CNT_EN
    .contention_cnt_o (contention_cnt_o),
    .lock_stall_cnt_o (lock_stall_cnt_o),
`endif
    .proto_err_o    (proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the list of outstanding requester IDs, the requester whose
  // address phase is pending (-1 if none), the round-robin favourite and the sticky error.
  int m_q[$];
  int m_held  = -1;
  int m_prio  = 0;
  bit m_perr  = 0;
  bit m_ready = 0;

  always @(negedge clk) begin : compare
    int         cand;
    bit         e_req;
    bit         e_resp;
    logic [1:0] e_gnt;
    logic [1:0] e_rv;
    if (rst) begin
      m_q.delete();
      m_held  = -1;
      m_prio  = 0;
      m_perr  = 0;
      m_ready = 1;
    end else if (m_ready) begin
      if (m_held >= 0)          cand = m_held;
      else if (req_i == 2'b10)  cand = 1;
      else if (req_i == 2'b11)  cand = m_prio;
      else                      cand = 0;
      e_req  = req_i[cand] && ((m_q.size() < MAX) || (m_held >= 0));
      e_gnt  = 2'b00;
      if (e_req && instr_gnt_i) e_gnt[cand] = 1'b1;
      e_resp = instr_rvalid_i && (m_q.size() != 0);
      e_rv   = 2'b00;
      if (e_resp) e_rv[m_q[0]] = 1'b1;

      check("cmp_instr_req", instr_req_o, e_req);
      if (e_req) check("cmp_instr_addr", instr_addr_o, addr_i[cand]);
      check("cmp_gnt", gnt_o, e_gnt);
      check("cmp_rvalid", rvalid_o, e_rv);
      check("cmp_rdata", rdata_o, instr_rdata_i);
      check("cmp_err", err_o, instr_err_i);
      check("cmp_busy", busy_o, (m_q.size() != 0) || e_req);
      check("cmp_proto_err", proto_err_o, m_perr);

      if (instr_rvalid_i && (m_q.size() == 0)) m_perr = 1;
      if (e_resp) void'(m_q.pop_front());
      if (e_gnt != 2'b00) begin
        m_q.push_back(cand);
        if (req_i == 2'b11) m_prio = 1 - cand;
        m_held = -1;
      end else if (e_req) begin
        m_held = cand;
      end
    end
  end

  task automatic set_in(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                        input logic gnt, input logic rv, input logic [31:0] rd, input logic er);
    req_i          = req;
    addr_i[0]      = a0;
    addr_i[1]      = a1;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    instr_err_i    = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #3;
    check("reset_gnt", gnt_o, 2'b00);
    check("reset_rvalid", rvalid_o, 2'b00);
    check("reset_instr_req", instr_req_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_proto_err", proto_err_o, 1'b0);
    tick();

    // Single requester, one fetch and its response.
    set_in(2'b01, 32'h100, 0, 1'b1, 1'b0, 0, 1'b0); #3;
    check("single_req", instr_req_o, 1'b1);
    check("single_addr", instr_addr_o, 32'h100);
    check("single_gnt", gnt_o, 2'b01);
    tick();
    set_in(2'b00, 32'h100, 0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0); #3;
    check("single_rvalid", rvalid_o, 2'b01);
    check("single_rdata", rdata_o, 32'hDEAD_BEEF);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0); #3;
    check("single_idle_busy", busy_o, 1'b0);
    tick();

    // Contention: grants alternate starting from requester 0, responses follow issue order.
    set_in(2'b11, 32'h200, 32'h300, 1'b1, 1'b0, 0, 1'b0); #3;
    check("rr_gnt_a", gnt_o, 2'b01);
    check("rr_addr_a", instr_addr_o, 32'h200);
    tick();
    set_in(2'b11, 32'h200, 32'h300, 1'b1, 1'b1, 32'hA0, 1'b0); #3;
    check("rr_gnt_b", gnt_o, 2'b10);
    check("rr_addr_b", instr_addr_o, 32'h300);
    check("rr_rv_b", rvalid_o, 2'b01);
    tick();
    set_in(2'b11, 32'h200, 32'h300, 1'b1, 1'b1, 32'hA1, 1'b0); #3;
    check("rr_gnt_c", gnt_o, 2'b01);
    check("rr_rv_c", rvalid_o, 2'b10);
    tick();
    set_in(2'b11, 32'h200, 32'h300, 1'b1, 1'b1, 32'hA2, 1'b0); #3;
    check("rr_gnt_d", gnt_o, 2'b10);
    check("rr_rv_d", rvalid_o, 2'b01);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b1, 32'hA3, 1'b0); #3;
    check("rr_rv_e", rvalid_o, 2'b10);
    tick();
    set_in(2'b11, 32'h210, 32'h310, 1'b1, 1'b0, 0, 1'b0); #3;
    check("rr_gnt_f", gnt_o, 2'b01);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b1, 32'hA4, 1'b0); #3;
    check("rr_rv_g", rvalid_o, 2'b01);
    tick();

    // Lock: requester 1 now has priority but must wait for the stalled requester 0.
    set_in(2'b01, 32'h400, 32'h500, 1'b0, 1'b0, 0, 1'b0); #3;
    check("lock_addr_0", instr_addr_o, 32'h400);
    check("lock_gnt_0", gnt_o, 2'b00);
    tick();
    for (int i = 1; i < 3; i++) begin
      set_in(2'b11, 32'h400, 32'h500, 1'b0, 1'b0, 0, 1'b0); #3;
      check("lock_addr_hold", instr_addr_o, 32'h400);
      check("lock_req_hold", instr_req_o, 1'b1);
      check("lock_gnt_hold", gnt_o, 2'b00);
      tick();
    end
    set_in(2'b11, 32'h400, 32'h500, 1'b1, 1'b0, 0, 1'b0); #3;
    check("lock_release_gnt", gnt_o, 2'b01);
    tick();
    set_in(2'b10, 32'h400, 32'h500, 1'b1, 1'b1, 32'hB0, 1'b0); #3;
    check("lock_next_gnt", gnt_o, 2'b10);
    check("lock_next_addr", instr_addr_o, 32'h500);
    check("lock_next_rv", rvalid_o, 2'b01);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b1, 32'hB1, 1'b0); #3;
    check("lock_last_rv", rvalid_o, 2'b10);
    tick();

    // Full: issue stops at the limit and resumes only after the registered count drops.
    set_in(2'b01, 32'h600, 0, 1'b1, 1'b0, 0, 1'b0); #3;
    check("full_gnt_1", gnt_o, 2'b01);
    tick();
    #3;
    check("full_gnt_2", gnt_o, 2'b01);
    tick();
    #3;
    check("full_blocked_req", instr_req_o, 1'b0);
    check("full_blocked_busy", busy_o, 1'b1);
    tick();
    set_in(2'b01, 32'h600, 0, 1'b1, 1'b1, 32'h11, 1'b0); #3;
    check("full_rv_no_issue", instr_req_o, 1'b0);
    check("full_rv", rvalid_o, 2'b01);
    tick();
    set_in(2'b01, 32'h600, 0, 1'b1, 1'b1, 32'h22, 1'b0); #3;
    check("full_reissue_req", instr_req_o, 1'b1);
    check("full_reissue_gnt", gnt_o, 2'b01);
    check("full_reissue_rv", rvalid_o, 2'b01);
    tick();
    set_in(2'b01, 32'h600, 0, 1'b1, 1'b1, 32'h33, 1'b1); #3;
    check("full_err", err_o, 1'b1);
    check("full_still_issues", gnt_o, 2'b01);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0); #3;
    check("full_count_one_busy", busy_o, 1'b1);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b1, 32'h44, 1'b0); #3;
    check("full_drain_rv", rvalid_o, 2'b01);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0); #3;
    check("full_drained_busy", busy_o, 1'b0);
    tick();

    // Protocol error, sticky until reset; reset also drops in-flight IDs.
    set_in(2'b00, 0, 0, 1'b0, 1'b1, 32'h55, 1'b0); #3;
    check("perr_no_rv", rvalid_o, 2'b00);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0); #3;
    check("perr_set", proto_err_o, 1'b1);
    tick();
    set_in(2'b01, 32'h700, 0, 1'b1, 1'b0, 0, 1'b0); #3;
    check("perr_sticky", proto_err_o, 1'b1);
    check("perr_gnt", gnt_o, 2'b01);
    tick();
    rst = 1'b1;
    set_in(2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    tick();
    rst = 1'b0; #3;
    check("rst_proto_err", proto_err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b1, 32'h66, 1'b0); #3;
    check("rst_stale_rv", rvalid_o, 2'b00);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0); #3;
    check("rst_stale_perr", proto_err_o, 1'b1);
    tick();

`ifdef CV32E40P_ARB_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0; #3;
    check("perf_rst_contention", contention_cnt_o, 32'd0);
    check("perf_rst_lock_stall", lock_stall_cnt_o, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(2'b11, 32'h800, 32'h900, 1'b1, (i > 0), 32'hC0, 1'b0);
      tick();
    end
    set_in(2'b00, 0, 0, 1'b0, 1'b1, 32'hC1, 1'b0); #3;
    check("perf_contention", contention_cnt_o, 32'd5);
    tick();
    rst = 1'b1;
    set_in(2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    tick();
    rst = 1'b0;
    set_in(2'b01, 32'h800, 32'h900, 1'b0, 1'b0, 0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(2'b11, 32'h800, 32'h900, 1'b0, 1'b0, 0, 1'b0);
      tick();
    end
    set_in(2'b01, 32'h800, 32'h900, 1'b1, 1'b0, 0, 1'b0); #3;
    check("perf_lock_stall", lock_stall_cnt_o, 32'd3);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b1, 32'hC2, 1'b0);
    tick();
    set_in(2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    tick();
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_instr_port_arbiter.md
Name: cv32e40p_instr_port_arbiter

Overview:
- Shares the single OBI instruction memory port between two requesters: requester 0 is the IF-stage prefetch buffer, requester 1 is a secondary fetch master (debug program-buffer fetch or memory scrubber).
- Round-robin grant arbitration; OBI address-phase stability is held per requester.
- Tracks outstanding transactions and routes each response (rvalid/rdata/err) back to the requester that issued it, in order.
- Sits between the prefetch buffer/PMP path and the core instruction bus pins.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..4); sets the response-ID FIFO depth.
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived; do not override).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_i  in  2  per-requester OBI request, index 0 = prefetch, 1 = secondary
- addr_i  in  2x32  per-requester fetch address
- gnt_o  out  2  per-requester grant
- rvalid_o  out  2  per-requester response valid
- rdata_o  out  32  response data, shared by both requesters, qualified by rvalid_o
- err_o  out  1  response bus error, qualified by rvalid_o
- instr_req_o  out  1  downstream request
- instr_addr_o  out  32  downstream address
- instr_gnt_i  in  1  downstream grant
- instr_rvalid_i  in  1  downstream response valid
- instr_rdata_i  in  32  downstream response data
- instr_err_i  in  1  downstream response error
- busy_o  out  1  outstanding count != 0 or instr_req_o high
- proto_err_o  out  1  sticky: instr_rvalid_i seen with zero outstanding

Behaviour:
- Reset (rst=1 at posedge): outstanding count = 0, FIFO empty, rr_prio = 0, lock = 0, proto_err_o = 0.
  - All outputs are combinational from this state, so after reset: gnt_o = 0, rvalid_o = 0, instr_req_o = 0, busy_o = 0.
  - Reset mid-transaction discards in-flight IDs; a later rvalid then sets proto_err_o.
- Selection:
  - If lock = 1, sel = lock_id.
  - Else if exactly one req_i bit is set, sel = that bit.
  - Else if both are set, sel = rr_prio.
- Issue gating: instr_req_o = req_i[sel] & (count < MAX_OUTSTANDING | lock). instr_addr_o = addr_i[sel].
- Lock (OBI stability):
  - Set lock = 1, lock_id = sel when instr_req_o & ~instr_gnt_i.
  - Clear lock on the cycle instr_req_o & instr_gnt_i.
  - While locked, the other requester is never granted, even if it has priority.
- Grant: gnt_o[sel] = instr_req_o & instr_gnt_i; the other gnt_o bit is 0. Zero-cycle pass-through.
- On a grant:
  - Push sel into the ID FIFO.
  - rr_prio <= ~sel, but only if both req_i bits were high that cycle; otherwise rr_prio is unchanged.
- Response routing:
  - rvalid_o[fifo_head] = instr_rvalid_i & (count != 0); the other bit is 0.
  - rdata_o = instr_rdata_i and err_o = instr_err_i, unregistered.
  - On rvalid: pop the FIFO.
- Counter:
  - +1 on grant only; -1 on rvalid only.
  - Grant and rvalid in the same cycle: count unchanged; FIFO pushes and pops simultaneously.
  - FIFO pointers wrap modulo MAX_OUTSTANDING.
- Full (count = MAX_OUTSTANDING):
  - No new request is issued until a response arrives.
  - A response and a new issue may occur in the same cycle only once count has dropped below the limit, i.e. issue is gated on the registered count, not on the same-cycle rvalid.
- Empty: instr_rvalid_i with count = 0 is ignored (no rvalid_o) and sets proto_err_o, which stays set until rst.
- Responses are in order; the OBI slave must respond in order. No reordering logic.

Optional Feature:
- Macro: CV32E40P_ARB_PERF_CNT_EN.
- Defined: adds output ports contention_cnt_o [31:0] and lock_stall_cnt_o [31:0], both synchronously reset to 0.
  - contention_cnt_o increments on cycles where both req_i bits are high.
  - lock_stall_cnt_o increments on cycles where lock = 1 and the non-locked requester has req_i high.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single requester, gnt tied 1: req_i = 2'b01, addr_i[0] = 0x100 for 1 cycle -> instr_req_o = 1, instr_addr_o = 0x100, gnt_o = 2'b01; rvalid with rdata 0xDEADBEEF next cycle -> rvalid_o = 2'b01, rdata_o = 0xDEADBEEF, count returns to 0.
- Contention: req_i = 2'b11 held, gnt = 1 every cycle, MAX = 2, rvalid 1 cycle after each grant -> grants alternate 01, 10, 01, 10 starting from requester 0; responses routed in matching order.
- Lock: req_i = 2'b01 with instr_gnt_i = 0 for 3 cycles, requester 1 raises req on cycle 1 -> sel stays 0 and instr_addr_o is stable for all 3 cycles; gnt_o[1] = 0 until requester 0 is granted.
- Full: MAX = 2, two grants with no rvalid -> instr_req_o = 0 despite req_i = 01; rvalid -> count = 1, instr_req_o = 1 next cycle; same-cycle grant + rvalid keeps count = 1.
- Protocol error and reset: instr_rvalid_i = 1 with count = 0 -> rvalid_o = 00, proto_err_o = 1 and stays set; rst = 1 for 1 cycle -> proto_err_o = 0, busy_o = 0.
- CV32E40P_ARB_PERF_CNT_EN defined: 5 cycles of req_i = 11 -> contention_cnt_o = 5; requester 0 locked 3 cycles with requester 1 waiting -> lock_stall_cnt_o = 3.
